// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - decode/execute pipeline register with load-use bubbles
// and writeback refresh of operands held by a downstream stall.

`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef REG_W
`define REG_W 5
`endif

module id_ex_stage #(
  parameter int DATA_W       = `DATA_W,
  parameter int REG_W        = `REG_W,
  parameter int CTRL_W       = 16,
  parameter int LOAD_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_a1,
  input  logic [REG_W-1:0]  id_a2,
  input  logic [REG_W-1:0]  id_a3,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_is_load,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_a3,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic              mem_stall,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_a1,
  output logic [REG_W-1:0]  ex_a2,
  output logic [REG_W-1:0]  ex_a3,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_is_load,
  output logic              id_stall
);

  typedef enum logic {RUN, BUBBLE} state_t;
  typedef enum logic [2:0] {ACT_FLUSH, ACT_HOLD, ACT_DRAIN, ACT_BUBBLE, ACT_CAPTURE} act_t;

  logic [1:0] cnt;
  state_t     state;
  act_t       act;
  logic       hazard;
  logic       refresh1;
  logic       refresh2;

  assign state  = (cnt != 2'd0) ? BUBBLE : RUN;
  assign hazard = ex_valid & ex_is_load & (ex_a3 != '0) & id_valid &
                  ((id_a1 == ex_a3) | (id_a2 == ex_a3));
  assign id_stall = mem_stall | hazard | (state == BUBBLE);

  // r0 is never refreshed, so a held operand read from r0 stays at its captured value.
  assign refresh1 = wb_we & (wb_a3 != '0) & (wb_a3 == ex_a1);
  assign refresh2 = wb_we & (wb_a3 != '0) & (wb_a3 == ex_a2);

  always_comb begin
    act = ACT_CAPTURE;
    if (ex_flush)
      act = ACT_FLUSH;
    else if (mem_stall)
      act = ACT_HOLD;
    else if (state == BUBBLE)
      act = ACT_DRAIN;
    else if (hazard)
      act = ACT_BUBBLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_a1      <= '0;
      ex_a2      <= '0;
      ex_a3      <= '0;
      ex_op1     <= '0;
      ex_op2     <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
      ex_is_load <= 1'b0;
      cnt        <= 2'd0;
    end else begin
      case (act)
        ACT_FLUSH: begin
          ex_valid <= 1'b0;
          cnt      <= 2'd0;
        end
        ACT_HOLD: begin
          if (refresh1) ex_op1 <= wb_wd;
          if (refresh2) ex_op2 <= wb_wd;
        end
        ACT_DRAIN: begin
          ex_valid <= 1'b0;
          cnt      <= cnt - 2'd1;
        end
        ACT_BUBBLE: begin
          ex_valid <= 1'b0;
          cnt      <= 2'(LOAD_BUBBLES - 1);
        end
        default: begin
          ex_valid   <= id_valid;
          ex_a1      <= id_a1;
          ex_a2      <= id_a2;
          ex_a3      <= id_a3;
          ex_op1     <= id_rd1;
          ex_op2     <= id_rd2;
          ex_imm     <= id_imm;
          ex_ctrl    <= id_ctrl;
          ex_is_load <= id_is_load;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage with LOAD_BUBBLES=1
// (main instance) and LOAD_BUBBLES=2 (second instance sharing the same inputs).

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_a1, id_a2, id_a3;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [15:0] id_ctrl;
  logic        id_is_load;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic        mem_stall;
  logic        ex_flush;

  logic        ex_valid, ex_is_load, id_stall;
  logic [4:0]  ex_a1, ex_a2, ex_a3;
  logic [31:0] ex_op1, ex_op2, ex_imm;
  logic [15:0] ex_ctrl;

  logic        b_ex_valid, b_ex_is_load, b_id_stall;
  logic [4:0]  b_ex_a1, b_ex_a2, b_ex_a3;
  logic [31:0] b_ex_op1, b_ex_op2, b_ex_imm;
  logic [15:0] b_ex_ctrl;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(16), .LOAD_BUBBLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_a1(id_a1), .id_a2(id_a2),
    .id_a3(id_a3), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_is_load(id_is_load), .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .mem_stall(mem_stall), .ex_flush(ex_flush), .ex_valid(ex_valid), .ex_a1(ex_a1),
    .ex_a2(ex_a2), .ex_a3(ex_a3), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .ex_is_load(ex_is_load), .id_stall(id_stall)
  );

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(16), .LOAD_BUBBLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_a1(id_a1), .id_a2(id_a2),
    .id_a3(id_a3), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_is_load(id_is_load), .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd),
    .mem_stall(mem_stall), .ex_flush(ex_flush), .ex_valid(b_ex_valid), .ex_a1(b_ex_a1),
    .ex_a2(b_ex_a2), .ex_a3(b_ex_a3), .ex_op1(b_ex_op1), .ex_op2(b_ex_op2),
    .ex_imm(b_ex_imm), .ex_ctrl(b_ex_ctrl), .ex_is_load(b_ex_is_load),
    .id_stall(b_id_stall)
  );

  typedef struct {
    logic        v;
    logic        chk;
    logic [4:0]  a1, a2, a3;
    logic [31:0] o1, o2, im;
    logic [15:0] c;
    logic        ld;
  } exp_t;

  exp_t  exp_q[$];
  string nm_q[$];
  exp_t  last_e;

  // Expected EX contents after the coming posedge: one push per cycle.
  task automatic sb_push(input string nm, input exp_t e);
    exp_q.push_back(e);
    nm_q.push_back(nm);
    last_e = e;
  endtask

  function automatic exp_t from_id();
    exp_t e;
    e.v = id_valid; e.chk = id_valid;
    e.a1 = id_a1; e.a2 = id_a2; e.a3 = id_a3;
    e.o1 = id_rd1; e.o2 = id_rd2; e.im = id_imm; e.c = id_ctrl; e.ld = id_is_load;
    return e;
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e = last_e;
    e.v = 1'b0; e.chk = 1'b0;
    return e;
  endfunction

  task automatic set_id(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] im, input logic [15:0] c, input logic ld);
    id_valid = v; id_a1 = a1; id_a2 = a2; id_a3 = a3;
    id_rd1 = r1; id_rd2 = r2; id_imm = im; id_ctrl = c; id_is_load = ld;
  endtask

  always @(posedge clk) begin
    exp_t  e;
    string nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = nm_q.pop_front();
      n_chk++;
      if (ex_valid !== e.v) begin
        n_fail++;
        $display("FAIL %s ex_valid got %0b want %0b", nm, ex_valid, e.v);
      end
      if (e.chk) begin
        n_chk++;
        if ({ex_a1, ex_a2, ex_a3, ex_op1, ex_op2, ex_imm, ex_ctrl, ex_is_load} !==
            {e.a1, e.a2, e.a3, e.o1, e.o2, e.im, e.c, e.ld}) begin
          n_fail++;
          $display("FAIL %s fields got a=%0d/%0d/%0d op=%h/%h imm=%h ctrl=%h ld=%0b want a=%0d/%0d/%0d op=%h/%h imm=%h ctrl=%h ld=%0b",
                   nm, ex_a1, ex_a2, ex_a3, ex_op1, ex_op2, ex_imm, ex_ctrl, ex_is_load,
                   e.a1, e.a2, e.a3, e.o1, e.o2, e.im, e.c, e.ld);
        end
      end
    end
  end

  task automatic test_reset();
    @(negedge clk); #1;
    n_chk++;
    if ({ex_valid, ex_a1, ex_a2, ex_a3, ex_op1, ex_op2, ex_imm, ex_ctrl, ex_is_load} !== '0) begin
      n_fail++;
      $display("FAIL reset_ex got valid=%0b op1=%h ctrl=%h want all zero", ex_valid, ex_op1, ex_ctrl);
    end
    n_chk++;
    if (id_stall !== 1'b0 || b_id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall got %0b/%0b want 0/0", id_stall, b_id_stall);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_id(1, 5'd2, 5'd3, 5'd1, 32'h11, 32'h22, 32'h5, 16'h0101, 0);
    sb_push("b2b_add_r1", from_id());
    #1; n_chk++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall1 got %0b want 0", id_stall); end
    @(negedge clk);
    set_id(1, 5'd1, 5'd4, 5'd2, 32'h33, 32'h44, 32'h6, 16'h0202, 0);
    sb_push("b2b_add_r2", from_id());
    #1; n_chk++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall2 got %0b want 0", id_stall); end
    @(negedge clk);
    id_valid = 1'b0;
    sb_push("b2b_idle", bubble());
  endtask

  task automatic test_load_use();
    @(negedge clk);
    set_id(1, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8, 16'h0F00, 1);
    sb_push("lu_load", from_id());
    @(negedge clk);
    set_id(1, 5'd5, 5'd2, 5'd6, 32'h55, 32'h22, 32'h0, 16'h0003, 0);
    sb_push("lu_bubble", bubble());
    #1; n_chk++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL lu_hazard_stall got %0b want 1", id_stall); end
    @(negedge clk);
    sb_push("lu_add", from_id());
    #1; n_chk++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_release got %0b want 0", id_stall); end
    n_chk++;
    if (b_ex_valid !== 1'b0 || b_id_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL lu2_bubble1 got valid=%0b stall=%0b want 0/1", b_ex_valid, b_id_stall);
    end
    @(negedge clk);
    sb_push("lu_add_again", from_id());
    #1; n_chk++;
    if (b_ex_valid !== 1'b0 || b_id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL lu2_bubble2 got valid=%0b stall=%0b want 0/0", b_ex_valid, b_id_stall);
    end
    @(negedge clk);
    n_chk++;
    if (b_ex_valid !== 1'b1 || b_ex_a1 !== 5'd5 || b_ex_a3 !== 5'd6) begin
      n_fail++;
      $display("FAIL lu2_capture got valid=%0b a1=%0d a3=%0d want 1/5/6", b_ex_valid, b_ex_a1, b_ex_a3);
    end
    id_valid = 1'b0;
    sb_push("lu_idle", bubble());
  endtask

  task automatic test_r0_load();
    @(negedge clk);
    set_id(1, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 32'h3, 16'h0F00, 1);
    sb_push("r0_load", from_id());
    @(negedge clk);
    set_id(1, 5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h9, 16'h0004, 0);
    sb_push("r0_use", from_id());
    #1; n_chk++;
    if (id_stall !== 1'b0 || b_id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_no_stall got %0b/%0b want 0/0", id_stall, b_id_stall);
    end
    @(negedge clk);
    id_valid = 1'b0;
    sb_push("r0_idle", bubble());
  endtask

  task automatic test_mem_stall_refresh();
    exp_t e;
    @(negedge clk);
    set_id(1, 5'd3, 5'd4, 5'd8, 32'h10, 32'h20, 32'h30, 16'h00AA, 0);
    sb_push("ms_capture", from_id());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_stall = 1'b1;
      set_id(1, 5'd9, 5'd10, 5'd11, 32'hDEAD, 32'hBEEF, 32'h77, 16'h5555, 0);
      wb_we = (i == 1); wb_a3 = 5'd3; wb_wd = 32'hAB;
      e = last_e;
      if (i >= 1) e.o1 = 32'hAB;
      sb_push("ms_hold", e);
      #1; n_chk++;
      if (id_stall !== 1'b1) begin n_fail++; $display("FAIL ms_stall%0d got %0b want 1", i, id_stall); end
    end
    @(negedge clk);
    mem_stall = 1'b0; wb_we = 1'b0;
    set_id(1, 5'd0, 5'd6, 5'd12, 32'h0, 32'h66, 32'h1, 16'h00BB, 0);
    sb_push("ms2_capture", from_id());
    @(negedge clk);
    mem_stall = 1'b1; wb_we = 1'b1; wb_a3 = 5'd0; wb_wd = 32'hFF;
    sb_push("ms2_no_r0_refresh", last_e);
    @(negedge clk);
    wb_a3 = 5'd6; wb_wd = 32'h77;
    e = last_e; e.o2 = 32'h77;
    sb_push("ms2_refresh_op2", e);
    @(negedge clk);
    mem_stall = 1'b0; wb_we = 1'b0; id_valid = 1'b0;
    sb_push("ms_idle", bubble());
  endtask

  task automatic test_flush_hazard();
    @(negedge clk);
    set_id(1, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8, 16'h0F00, 1);
    sb_push("fl_load", from_id());
    @(negedge clk);
    set_id(1, 5'd5, 5'd2, 5'd6, 32'h55, 32'h22, 32'h0, 16'h0003, 0);
    ex_flush = 1'b1;
    sb_push("fl_killed", bubble());
    #1; n_chk++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL fl_hazard_stall got %0b want 1", id_stall); end
    @(negedge clk);
    ex_flush = 1'b0;
    sb_push("fl_capture_no_bubble", from_id());
    #1; n_chk++;
    if (id_stall !== 1'b0 || b_id_stall !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_no_bubble got %0b/%0b want 0/0", id_stall, b_id_stall);
    end
    @(negedge clk);
    id_valid = 1'b0;
    sb_push("fl_idle", bubble());
  endtask

  task automatic test_reset_mid_bubble();
    @(negedge clk);
    set_id(1, 5'd1, 5'd0, 5'd5, 32'h100, 32'h0, 32'h8, 16'h0F00, 1);
    sb_push("rb_load", from_id());
    @(negedge clk);
    set_id(1, 5'd5, 5'd2, 5'd6, 32'h55, 32'h22, 32'h0, 16'h0003, 0);
    sb_push("rb_bubble", bubble());
    @(negedge clk);
    n_chk++;
    if (b_id_stall !== 1'b1) begin n_fail++; $display("FAIL rb_in_bubble got %0b want 1", b_id_stall); end
    rst_n = 1'b0;
    set_id(1, 5'd1, 5'd2, 5'd9, 32'hC1, 32'hC2, 32'hC3, 16'h0C0C, 0);
    #1; n_chk++;
    if (b_ex_valid !== 1'b0 || b_id_stall !== 1'b0 || ex_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rb_async got valid=%0b stall=%0b valid1=%0b want 0/0/0", b_ex_valid, b_id_stall, ex_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_e = from_id();
    sb_push("rb_first_capture", from_id());
    @(negedge clk);
    n_chk++;
    if (b_ex_valid !== 1'b1 || b_ex_a3 !== 5'd9) begin
      n_fail++;
      $display("FAIL rb2_first_capture got valid=%0b a3=%0d want 1/9", b_ex_valid, b_ex_a3);
    end
    id_valid = 1'b0;
    sb_push("rb_idle", bubble());
  endtask

  initial begin
    rst_n = 1'b0;
    set_id(0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 16'h0, 0);
    wb_we = 1'b0; wb_a3 = 5'd0; wb_wd = 32'h0;
    mem_stall = 1'b0; ex_flush = 1'b0;
    last_e = from_id();
    test_reset();
    test_back_to_back();
    test_load_use();
    test_r0_load();
    test_mem_stall_refresh();
    test_flush_hazard();
    test_reset_mid_bubble();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
